fc_rx_word_sync: RTL and testbench

Parametrised Fibre Channel receive word-synchronisation block. It sits between the 8b/10b PHY's decoded parallel output (32 bits plus K flags, error flags and sync status) and the FC link logic. It rotates the byte stream so K28.5 always lands in character lane 0, and runs the FC transmission-word acquire/loss-of-sync state machine with configurable thresholds. It emits a 36-bit stream (9 bits per character: K flag plus byte) and keeps a saturating character-error counter.

---
 rtl/fc_rx_word_sync.sv | 227 ++++++++++++++++++++++
 tb/tb_fc_rx_word_sync.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fc_rx_word_sync.sv
// Fibre Channel receive word synchroniser.
// Rotates the decoded PHY byte stream so that K28.5 sits in character lane 0.
// Runs the transmission-word acquire / loss-of-sync state machine.
// Counts errored characters in a saturating counter.
// Ports:
//   clk, reset_n      receive clock, synchronous active-low reset
//   rx_data/datak     decoded characters and K flags (char0 = [7:0], first on line)
//   rx_errdetect      per-char code violation
//   rx_disperr        per-char disparity error
//   rx_in_valid       PHY ready / lane sync
//   out_data          aligned word, char i = {K, byte} at [9i+8:9i]
//   out_valid         aligned word valid while in SYNC
//   out_is_os         aligned word is a valid ordered set
//   sync, sync_lost   SYNC status and one-cycle loss pulse
//   align_lane        current rotation
//   err_count         saturating errored-character count
//   err_clear         synchronous clear of err_count
module fc_rx_word_sync #(
   parameter int unsigned ACQ_OS        = 3,
   parameter int unsigned LOSS_INVALID  = 4,
   parameter int unsigned RECOVER_VALID = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      rx_data,
   input  logic [3:0]       rx_datak,
   input  logic [3:0]       rx_errdetect,
   input  logic [3:0]       rx_disperr,
   input  logic             rx_in_valid,
   output logic [35:0]      out_data,
   output logic             out_valid,
   output logic             out_is_os,
   output logic             sync,
   output logic             sync_lost,
   output logic [1:0]       align_lane,
   output logic [CNT_W-1:0] err_count,
   input  logic             err_clear
);

   localparam int unsigned OS_W  = $clog2(ACQ_OS + 1);
   localparam int unsigned INV_W = $clog2(LOSS_INVALID + 1);
   localparam int unsigned RUN_W = $clog2(RECOVER_VALID + 1);
   localparam int unsigned SUM_W = CNT_W + 3;

   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(ACQ_OS - 1);
   localparam logic [INV_W-1:0] INV_LAST = INV_W'(LOSS_INVALID - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RECOVER_VALID - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_HUNT = 2'd0,
      S_ACQ  = 2'd1,
      S_SYNC = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [OS_W-1:0]  os_cnt, os_n;
   logic [INV_W-1:0] inv_cnt, inv_n;
   logic [RUN_W-1:0] valid_run, run_n;
   logic [1:0]       lane_n;

   logic [31:0]      stage_data;
   logic [3:0]       stage_k;
   logic [3:0]       stage_bad;
   logic             stage_valid;

   logic [3:0]       rx_bad;
   logic [71:0]      cat_chars;
   logic [7:0]       cat_bad;
   logic [6:0]       sel_bit;
   logic [35:0]      aligned;
   logic [3:0]       aligned_bad;
   logic [3:0]       aligned_k;
   logic             avail;
   logic             word_ok;
   logic             word_os;
   logic [3:0]       raw_k285;
   logic             hit;
   logic [1:0]       hit_lane;
   logic [2:0]       bad_num;
   logic [SUM_W-1:0] err_sum;
   logic [CNT_W-1:0] err_n;

   // Aligned word: chars L..3 of the stage word, then chars 0..L-1 of the current input.
   always_comb begin
      rx_bad    = rx_errdetect | rx_disperr;
      cat_chars = '0;
      for (int i = 0; i < 4; i++) begin
         cat_chars[9*i +: 9]      = {stage_k[i], stage_data[8*i +: 8]};
         cat_chars[36 + 9*i +: 9] = {rx_datak[i], rx_data[8*i +: 8]};
      end
      cat_bad     = {rx_bad, stage_bad};
      sel_bit     = 7'(align_lane) * 7'd9;
      aligned     = cat_chars[sel_bit +: 36];
      aligned_bad = cat_bad[3'(align_lane) +: 4];
      aligned_k   = {aligned[35], aligned[26], aligned[17], aligned[8]};
      avail       = stage_valid & rx_in_valid;
      word_ok     = avail & ~(|aligned_bad) & ~(|aligned_k[3:1]);
      word_os     = word_ok & aligned_k[0] & (aligned[7:0] == 8'hBC);
   end

   // Raw K28.5 search for HUNT; the lowest qualifying lane wins.
   always_comb begin
      hit_lane = 2'd0;
      for (int i = 0; i < 4; i++) begin
         raw_k285[i] = rx_datak[i] & (rx_data[8*i +: 8] == 8'hBC) & ~rx_bad[i];
      end
      for (int i = 3; i >= 0; i--) begin
         if (raw_k285[i]) hit_lane = 2'(i);
      end
      hit = |raw_k285;
   end

   // Saturating error accumulation; clear discards this cycle's increment.
   always_comb begin
      bad_num = 3'(rx_bad[0]) + 3'(rx_bad[1]) + 3'(rx_bad[2]) + 3'(rx_bad[3]);
      err_sum = SUM_W'(err_count) + SUM_W'(bad_num);
      err_n   = err_count;
      if (err_clear) begin
         err_n = '0;
      end else if (rx_in_valid) begin
         err_n = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
      end
   end

   // Next-state and counter logic of the acquire / loss-of-sync machine.
   always_comb begin
      state_n = state;
      os_n    = os_cnt;
      inv_n   = inv_cnt;
      run_n   = valid_run;
      lane_n  = align_lane;
      case (state)
         S_HUNT: begin
            if (hit) begin
               lane_n  = hit_lane;
               os_n    = '0;
               state_n = S_ACQ;
            end
         end
         S_ACQ: begin
            if (!word_ok) begin
               state_n = S_HUNT;
            end else if (word_os) begin
               if (os_cnt == OS_LAST) begin
                  state_n = S_SYNC;
                  os_n    = '0;
               end else begin
                  os_n = os_cnt + OS_W'(1);
               end
            end
         end
         S_SYNC: begin
            if (!word_ok) begin
               run_n = '0;
               if (inv_cnt == INV_LAST) begin
                  state_n = S_HUNT;
               end else begin
                  inv_n = inv_cnt + INV_W'(1);
               end
            end else if (valid_run == RUN_LAST) begin
               run_n = '0;
               if (inv_cnt != '0) inv_n = inv_cnt - INV_W'(1);
            end else begin
               run_n = valid_run + RUN_W'(1);
            end
         end
         default: state_n = S_HUNT;
      endcase
      // Losing the PHY overrides every transition.
      if (!rx_in_valid) begin
         state_n = S_HUNT;
         os_n    = '0;
         lane_n  = align_lane;
      end
      if (state_n != S_SYNC) begin
         inv_n = '0;
         run_n = '0;
      end
   end

   // FSM state and counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_HUNT;
         os_cnt     <= '0;
         inv_cnt    <= '0;
         valid_run  <= '0;
         align_lane <= 2'd0;
      end else begin
         state      <= state_n;
         os_cnt     <= os_n;
         inv_cnt    <= inv_n;
         valid_run  <= run_n;
         align_lane <= lane_n;
      end
   end

   // Stage word, registered outputs and error counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stage_data  <= '0;
         stage_k     <= '0;
         stage_bad   <= '0;
         stage_valid <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_is_os   <= 1'b0;
         sync        <= 1'b0;
         sync_lost   <= 1'b0;
         err_count   <= '0;
      end else begin
         stage_data  <= rx_data;
         stage_k     <= rx_datak;
         stage_bad   <= rx_bad;
         stage_valid <= rx_in_valid;
         out_data    <= aligned;
         out_valid   <= (state == S_SYNC) & avail;
         out_is_os   <= word_os;
         sync        <= (state_n == S_SYNC);
         sync_lost   <= (state == S_SYNC) & (state_n != S_SYNC);
         err_count   <= err_n;
      end
   end

endmodule

// File: tb/tb_fc_rx_word_sync.sv
// Directed bench for fc_rx_word_sync (CNT_W=4 so saturation is reachable).
module tb_fc_rx_word_sync;

   localparam int unsigned CNT_W = 4;
   localparam logic [35:0] IDLE_OUT = {9'h0B5, 9'h0B5, 9'h095, 9'h1BC};

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [31:0]      rx_data = '0;
   logic [3:0]       rx_datak = '0;
   logic [3:0]       rx_errdetect = '0;
   logic [3:0]       rx_disperr = '0;
   logic             rx_in_valid = 1'b0;
   logic             err_clear = 1'b0;
   logic [35:0]      out_data;
   logic             out_valid;
   logic             out_is_os;
   logic             sync;
   logic             sync_lost;
   logic [1:0]       align_lane;
   logic [CNT_W-1:0] err_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] pat_data;
   logic [3:0]  pat_k;

   fc_rx_word_sync #(
      .ACQ_OS(3), .LOSS_INVALID(4), .RECOVER_VALID(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_data(rx_data), .rx_datak(rx_datak),
      .rx_errdetect(rx_errdetect), .rx_disperr(rx_disperr),
      .rx_in_valid(rx_in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_is_os(out_is_os),
      .sync(sync), .sync_lost(sync_lost), .align_lane(align_lane),
      .err_count(err_count), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                       input logic [3:0] dp, input logic v, input logic clr);
      rx_data      = d;
      rx_datak     = k;
      rx_errdetect = e;
      rx_disperr   = dp;
      rx_in_valid  = v;
      err_clear    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(pat_data, pat_k, 4'h0, 4'h0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset values
      step(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      step(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("rst_out_data", out_data, 36'h0);
      chk("rst_out_valid", 36'(out_valid), 36'h0);
      chk("rst_sync", 36'(sync), 36'h0);
      chk("rst_err_count", 36'(err_count), 36'h0);
      chk("rst_align_lane", 36'(align_lane), 36'h0);
      reset_n = 1'b1;

      // Aligned IDLE stream, lane 0
      pat_data = 32'hB5B595BC;
      pat_k    = 4'b0001;
      idle(3);
      chk("l0_sync_before", 36'(sync), 36'h0);
      idle(1);
      chk("l0_sync_after3os", 36'(sync), 36'h1);
      idle(1);
      chk("l0_out_valid", 36'(out_valid), 36'h1);
      chk("l0_out_data", out_data, IDLE_OUT);
      chk("l0_out_is_os", 36'(out_is_os), 36'h1);
      chk("l0_align_lane", 36'(align_lane), 36'h0);
      chk("l0_err_count", 36'(err_count), 36'h0);

      // IDLE stream at lane 2
      do_reset();
      pat_data = 32'h95BCB5B5;
      pat_k    = 4'b0100;
      idle(1);
      chk("l2_align_lane", 36'(align_lane), 36'h2);
      idle(3);
      chk("l2_sync", 36'(sync), 36'h1);
      idle(1);
      chk("l2_out_data", out_data, IDLE_OUT);
      chk("l2_out_is_os", 36'(out_is_os), 36'h1);
      chk("l2_out_valid", 36'(out_valid), 36'h1);

      // Four consecutive errored words drop SYNC on the fourth
      for (int i = 0; i < 3; i++) step(pat_data, pat_k, 4'b0001, 4'h0, 1'b1, 1'b0);
      chk("loss_sync_held", 36'(sync), 36'h1);
      chk("loss_no_pulse_yet", 36'(sync_lost), 36'h0);
      step(pat_data, pat_k, 4'b0001, 4'h0, 1'b1, 1'b0);
      chk("loss_sync_dropped", 36'(sync), 36'h0);
      chk("loss_pulse", 36'(sync_lost), 36'h1);
      chk("loss_err_count", 36'(err_count), 36'h4);
      idle(1);
      chk("loss_pulse_single", 36'(sync_lost), 36'h0);
      idle(3);
      chk("reacq_sync", 36'(sync), 36'h1);

      // 1 invalid + 2 valid repeated: inv_cnt never climbs past 1
      for (int i = 0; i < 21; i++) begin
         step(pat_data, pat_k, (i % 3 == 0) ? 4'b0001 : 4'b0000, 4'h0, 1'b1, 1'b0);
         chk("recover_sync", 36'(sync), 36'h1);
         chk("recover_no_loss", 36'(sync_lost), 36'h0);
      end
      chk("recover_err_count", 36'(err_count), 36'd11);

      // rx_in_valid low for one cycle while in SYNC
      step(pat_data, pat_k, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("inv_sync", 36'(sync), 36'h0);
      chk("inv_pulse", 36'(sync_lost), 36'h1);
      chk("inv_out_valid", 36'(out_valid), 36'h0);
      chk("inv_err_hold", 36'(err_count), 36'd11);
      idle(3);
      chk("inv_reacq_early", 36'(sync), 36'h0);
      idle(1);
      chk("inv_reacq_sync", 36'(sync), 36'h1);
      idle(1);
      chk("inv_reacq_valid", 36'(out_valid), 36'h1);
      chk("inv_reacq_data", out_data, IDLE_OUT);

      // Reset mid-operation
      do_reset();
      chk("midrst_sync", 36'(sync), 36'h0);
      chk("midrst_out_valid", 36'(out_valid), 36'h0);
      chk("midrst_out_is_os", 36'(out_is_os), 36'h0);
      chk("midrst_out_data", out_data, 36'h0);
      chk("midrst_err_count", 36'(err_count), 36'h0);
      chk("midrst_align_lane", 36'(align_lane), 36'h0);

      // K28.5 in lanes 1 and 3: lowest lane wins
      step(32'hBC00BC00, 4'b1010, 4'h0, 4'h0, 1'b1, 1'b0);
      chk("prio_align_lane", 36'(align_lane), 36'h1);

      // Saturation, clear priority and disparity counting
      do_reset();
      step(pat_data, pat_k, 4'h0, 4'h0, 1'b1, 1'b1);
      chk("sat_cleared", 36'(err_count), 36'h0);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("sat_4", 36'(err_count), 36'd4);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("sat_8", 36'(err_count), 36'd8);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("sat_12", 36'(err_count), 36'd12);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("sat_15", 36'(err_count), 36'd15);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("sat_hold", 36'(err_count), 36'd15);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b1);
      chk("clr_priority", 36'(err_count), 36'h0);
      step(pat_data, pat_k, 4'hF, 4'h0, 1'b1, 1'b0);
      chk("after_clr", 36'(err_count), 36'd4);
      step(pat_data, pat_k, 4'h0, 4'b0011, 1'b1, 1'b0);
      chk("disperr_count", 36'(err_count), 36'd6);
      step(pat_data, pat_k, 4'hF, 4'hF, 1'b0, 1'b0);
      chk("no_count_invalid", 36'(err_count), 36'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
